adc_capture_ctrl: RTL
=====================

// Module: adc_capture_ctrl
// PURPOSE
//  Parametrised ADC-to-frame-RAM capture controller feeding the VGA scope display.
//  Arms on enable, waits for a level/slope trigger (or free-runs), decimates the ADC stream
//  and writes DEPTH samples into the display RAM, then holds until the display side acks.
//  Sits between the ADC front end (clk_adc domain) and the dual-port sample RAM.
// PARAMETERS
//  DATA_W   8    ADC sample width
//  DEPTH    160  samples per frame (one per display column)
//  ADDR_W   8    RAM address width; DEPTH <= 2**ADDR_W
//  DECIM_W  8    decimation counter width
//  TIMEOUT  1024 auto-trigger timeout in clk_adc cycles (used only with AUTO_TRIG_EN)
// PORTS
//  clk_adc     in   1        ADC sample clock; all logic on rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  enable      in   1        level: arm/keep capture running; low aborts ARM/CAPTURE
//  adc_data    in   DATA_W   unsigned ADC sample, valid every clk_adc
//  trig_mode   in   1        0 = free-run (no trigger wait), 1 = triggered
//  trig_slope  in   1        0 = rising crossing, 1 = falling crossing
//  trig_level  in   DATA_W   trigger threshold (unsigned)
//  decim       in   DECIM_W  write one sample every decim+1 clocks; sampled on ARM entry
//  rd_done     in   1        display finished reading frame; 1-cycle pulse
//  wr_en       out  1        RAM write strobe
//  wr_addr     out  ADDR_W   RAM write address, 0..DEPTH-1
//  wr_data     out  DATA_W   RAM write data
//  busy        out  1        high in ARM or CAPTURE
//  triggered   out  1        1-cycle pulse on trigger detection
//  finished    out  1        level, high in DONE
// BEHAVIOUR
//  - Reset: state=IDLE; wr_en, wr_addr, wr_data, busy, triggered, finished all 0; prev sample 0.
//  - FSM IDLE->ARM when enable=1; latches decim, clears decim count, addr=0, prev_valid=0.
//  - ARM: trig_mode=0 -> CAPTURE next cycle. trig_mode=1 -> register prev=adc_data each cycle;
//    rising hit: prev_valid && prev<trig_level && adc_data>=trig_level; falling hit:
//    prev_valid && prev>=trig_level && adc_data<trig_level. No hit possible on first ARM cycle.
//    Hit -> triggered pulse, crossing sample is sample 0, enter CAPTURE.
//  - CAPTURE: decim counter counts 0..decim; sample taken when counter==0, incl. trigger cycle
//    (triggered) or first CAPTURE cycle (free-run). decim=0 -> every clock.
//  - Write latency: registered; wr_en/wr_addr/wr_data valid the cycle after adc_data sampled.
//  - wr_addr increments after each write; write at DEPTH-1 -> DONE next cycle; never wraps.
//  - DONE: finished=1, wr_en=0; stays until rd_done=1, then IDLE (re-arms next cycle if enable).
//  - enable=0 in ARM/CAPTURE: IDLE next cycle, no further writes, finished stays 0.
//  - enable=0 in DONE: ignored; only rd_done leaves DONE. rd_done outside DONE: ignored.
//  - enable rising and rd_done same cycle in DONE: IDLE, then ARM.
//  - trig_level/trig_slope/trig_mode sampled live; change mid-ARM applies immediately.
//  - reset_n low mid-capture: immediate return to reset values; partial frame left in RAM.
// CONFIGURATION
//  - AUTO_TRIG_EN defined: timeout counter runs in ARM when trig_mode=1; after TIMEOUT cycles
//    without hit, force trigger (triggered pulses, current sample is sample 0). Counter
//    clears on ARM entry.
//  - AUTO_TRIG_EN undefined: no timeout logic; ARM waits indefinitely; TIMEOUT unused.
// TESTING
//  - Free-run, decim=0, ramp adc_data=0,1,2..: 160 writes addr 0..159, data 0..159,
//    finished=1 after addr 159.
//  - trig_mode=1 rising, level=0x80, samples 0x70,0x7F,0x80: triggered at 0x80, wr_addr 0
//    holds 0x80.
//  - Falling slope, level=0x40, sine input: first written sample <0x40, previous >=0x40.
//  - decim=3, DEPTH=160: wr_en every 4th clk, 160 writes over 637 clks from first write.
//  - enable dropped at addr 50: no writes after 50, finished=0, IDLE; re-enable restarts at 0.
//  - DONE + rd_done pulse with enable=1: finished falls, busy rises 1 cycle later;
//    AUTO_TRIG_EN with DC input below level: triggered after exactly TIMEOUT cycles.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// ADC frame capture: arm on enable, wait for level/slope trigger or free-run, write DEPTH decimated samples to RAM.
// Latency: wr_en/wr_addr/wr_data registered, one clk_adc after the sample is taken; triggered aligns with write 0.
// No backpressure: the ADC stream is never stalled; the frame is held in DONE until rd_done. Option: AUTO_TRIG_EN.
module adc_capture_ctrl #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 160,
  parameter int ADDR_W  = 8,
  parameter int DECIM_W = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk_adc,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               trig_mode,
  input  logic               trig_slope,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic [DECIM_W-1:0] decim,
  input  logic               rd_done,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               triggered,
  output logic               finished
);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t              state, state_nxt;
  logic [DECIM_W-1:0]  decim_q;
  logic [DECIM_W-1:0]  dcnt;
  logic [ADDR_W-1:0]   addr;
  logic                full;
  logic [DATA_W-1:0]   prev;
  logic                prev_valid;
  logic                rise_hit;
  logic                fall_hit;
  logic                level_hit;
  logic                timeout_hit;
  logic                trig_hit;
  logic                take;
  logic                last_wr;

  assign rise_hit  = prev_valid && (prev <  trig_level) && (adc_data >= trig_level);
  assign fall_hit  = prev_valid && (prev >= trig_level) && (adc_data <  trig_level);
  assign level_hit = trig_slope ? fall_hit : rise_hit;

`ifdef AUTO_TRIG_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt;

  assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else if (state == ARM && trig_mode) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  // TIMEOUT only matters with the auto-trigger; this folds to constant 0.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  assign trig_hit = (state == ARM) && enable && trig_mode && (level_hit || timeout_hit);
  // full blocks the sample slot between the last take and its write landing.
  assign take     = enable && !full && (((state == CAPTURE) && (dcnt == '0)) || trig_hit);
  assign last_wr  = wr_en && (wr_addr == ADDR_W'(DEPTH - 1));

  assign busy     = (state == ARM) || (state == CAPTURE);
  assign finished = (state == DONE);

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ARM;
      ARM: begin
        if (!enable)                     state_nxt = IDLE;
        else if (!trig_mode || trig_hit) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (!enable)     state_nxt = IDLE;
        else if (last_wr) state_nxt = DONE;
      end
      DONE:    if (rd_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      triggered  <= 1'b0;
      decim_q    <= '0;
      dcnt       <= '0;
      addr       <= '0;
      full       <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      wr_en     <= take;
      triggered <= trig_hit;

      if (state == IDLE) begin
        if (enable) begin
          decim_q    <= decim;
          dcnt       <= '0;
          addr       <= '0;
          full       <= 1'b0;
          prev_valid <= 1'b0;
        end
      end else begin
        if (take) begin
          wr_addr <= addr;
          wr_data <= adc_data;
          addr    <= addr + 1'b1;
          if (addr == ADDR_W'(DEPTH - 1)) full <= 1'b1;
        end
        if ((state == CAPTURE) || trig_hit) begin
          dcnt <= (dcnt == decim_q) ? '0 : dcnt + 1'b1;
        end
        if (state == ARM && trig_mode) begin
          prev       <= adc_data;
          prev_valid <= 1'b1;
        end
      end
    end
  end

endmodule
